// File: rtl/end_screen_composer.sv
// End-of-game overlay: reveals NUM_LAYERS bitmap layers one at a time, then blinks one layer on a new high score.
// Optional macro END_SCREEN_COMPOSER_BG_FILL_EN fills non-drawing pixels with BG_COLOR while the screen is active.
module end_screen_composer #(
  parameter int NUM_LAYERS    = 3,
  parameter int RGB_W         = 8,
  parameter int REVEAL_FRAMES = 30,
  parameter int BLINK_FRAMES  = 15,
  parameter int BLINK_LAYER   = 0,
  parameter logic [RGB_W-1:0] BG_COLOR = '0
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic                        screenActive,
  input  logic                        newHighScore,
  input  logic [NUM_LAYERS-1:0]       layerDR,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  output logic                        screenDR,
  output logic [RGB_W-1:0]            screenRGB,
  output logic [1:0]                  screenState,
  output logic                        revealDone
);

  localparam int IDX_W = $clog2(NUM_LAYERS + 1);
  localparam int FC_W  = $clog2(REVEAL_FRAMES + 1);
  localparam int BC_W  = $clog2(BLINK_FRAMES + 1);
`ifdef END_SCREEN_COMPOSER_BG_FILL_EN
  localparam bit BG_FILL = 1'b1;
`else
  localparam bit BG_FILL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, REVEAL = 2'd1, SHOW = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   revealIdx_q, revealIdx_d;
  logic [FC_W-1:0]    frameCnt_q, frameCnt_d;
  logic [BC_W-1:0]    blinkCnt_q, blinkCnt_d;
  logic               blinkPhase_q, blinkPhase_d;
  logic               hsLatched_q, hsLatched_d;
  logic               screenDR_q, revealDone_q;
  logic [RGB_W-1:0]   screenRGB_q;
  logic [NUM_LAYERS-1:0] visible, active;
  logic               pixDr;
  logic [RGB_W-1:0]   pixRgb;

  // Dropping screenActive overrides every other transition and clears all sequencing state.
  always_comb begin
    state_d      = state_q;
    revealIdx_d  = revealIdx_q;
    frameCnt_d   = frameCnt_q;
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    hsLatched_d  = hsLatched_q;
    if (!screenActive) begin
      state_d      = IDLE;
      revealIdx_d  = '0;
      frameCnt_d   = '0;
      blinkCnt_d   = '0;
      blinkPhase_d = 1'b1;
      hsLatched_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = REVEAL;
          revealIdx_d = IDX_W'(1);
          frameCnt_d  = '0;
        end
        REVEAL: begin
          hsLatched_d = hsLatched_q | newHighScore;
          if (revealIdx_q == IDX_W'(NUM_LAYERS)) begin
            state_d      = SHOW;
            blinkCnt_d   = '0;
            blinkPhase_d = 1'b1;
          end else if (startOfFrame) begin
            if (frameCnt_q == FC_W'(REVEAL_FRAMES - 1)) begin
              frameCnt_d  = '0;
              revealIdx_d = revealIdx_q + IDX_W'(1);
            end else begin
              frameCnt_d = frameCnt_q + FC_W'(1);
            end
          end
        end
        SHOW: begin
          hsLatched_d = hsLatched_q | newHighScore;
          if (startOfFrame) begin
            if (blinkCnt_q == BC_W'(BLINK_FRAMES - 1)) begin
              blinkCnt_d   = '0;
              blinkPhase_d = ~blinkPhase_q;
            end else begin
              blinkCnt_d = blinkCnt_q + BC_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Priority mux: scan from the highest index down so the lowest requesting visible layer wins.
  always_comb begin
    visible = '0;
    for (int k = 0; k < NUM_LAYERS; k++)
      visible[k] = (state_q != IDLE) && (IDX_W'(k) < revealIdx_q);
    if (state_q == SHOW && hsLatched_q && !blinkPhase_q)
      visible[BLINK_LAYER] = 1'b0;
    active = layerDR & visible;
    pixDr  = |active;
    pixRgb = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--)
      if (active[k]) pixRgb = layerRGB[k*RGB_W +: RGB_W];
    if (BG_FILL && state_q != IDLE && !pixDr) begin
      pixDr  = 1'b1;
      pixRgb = BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= IDLE;
      revealIdx_q  <= '0;
      frameCnt_q   <= '0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b1;
      hsLatched_q  <= 1'b0;
      screenDR_q   <= 1'b0;
      screenRGB_q  <= '0;
      revealDone_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      revealIdx_q  <= revealIdx_d;
      frameCnt_q   <= frameCnt_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      hsLatched_q  <= hsLatched_d;
      screenDR_q   <= pixDr;
      screenRGB_q  <= pixRgb;
      revealDone_q <= (state_d == SHOW);
    end
  end

  assign screenDR    = screenDR_q;
  assign screenRGB   = screenRGB_q;
  assign screenState = state_q;
  assign revealDone  = revealDone_q;

endmodule

// File: tb/tb_end_screen_composer.sv
// Scoreboard bench for end_screen_composer: 3 layers, REVEAL_FRAMES=2, BLINK_FRAMES=3, BLINK_LAYER=0.
module tb_end_screen_composer;

  localparam logic [7:0] A = 8'hA1, B = 8'hB2, C = 8'hC3, BGC = 8'h25;
`ifdef END_SCREEN_COMPOSER_BG_FILL_EN
  localparam bit BGON = 1'b1;
`else
  localparam bit BGON = 1'b0;
`endif

  typedef struct packed {
    logic       dr;
    logic [7:0] rgb;
    logic [1:0] st;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic       rstN, act, sof, nhs;
    logic [2:0] ldr;
    exp_t       e;
  } row_t;

  logic clk = 1'b0;
  logic resetN, startOfFrame, screenActive, newHighScore;
  logic [2:0]  layerDR;
  logic [23:0] layerRGB;
  logic        screenDR, revealDone;
  logic [7:0]  screenRGB;
  logic [1:0]  screenState;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  end_screen_composer #(
    .NUM_LAYERS(3), .RGB_W(8), .REVEAL_FRAMES(2), .BLINK_FRAMES(3),
    .BLINK_LAYER(0), .BG_COLOR(BGC)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .screenActive(screenActive), .newHighScore(newHighScore),
    .layerDR(layerDR), .layerRGB(layerRGB),
    .screenDR(screenDR), .screenRGB(screenRGB),
    .screenState(screenState), .revealDone(revealDone)
  );

  function automatic row_t mk(logic rstN, logic act, logic sof, logic nhs, logic [2:0] ldr,
                              logic edr, logic [7:0] ergb, logic [1:0] est, logic edone);
    row_t r;
    r.rstN = rstN; r.act = act; r.sof = sof; r.nhs = nhs; r.ldr = ldr;
    r.e = '{dr: edr, rgb: ergb, st: est, done: edone};
    return r;
  endfunction

  task automatic test_reset();
    row_t rows[$];
    exp_t e, got;
    rows.push_back(mk(0, 1, 1, 1, 3'b111, 0, 8'h00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 8'h00, 0, 0));
    foreach (rows[i]) begin
      resetN = rows[i].rstN; screenActive = rows[i].act; startOfFrame = rows[i].sof;
      newHighScore = rows[i].nhs; layerDR = rows[i].ldr; sb.push_back(rows[i].e);
      @(posedge clk); #1;
      got = '{dr: screenDR, rgb: screenRGB, st: screenState, done: revealDone};
      e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL reset[%0d] got %h want %h", i, got, e); end
    end
  endtask

  task automatic test_reveal();
    row_t rows[$];
    exp_t e, got;
    rows.push_back(mk(1, 1, 0, 0, 3'b111, 0, 8'h00, 1, 0));
    rows.push_back(mk(1, 1, 0, 0, 3'b111, 1, A,     1, 0));
    rows.push_back(mk(1, 1, 0, 0, 3'b110, 0, 8'h00, 1, 0));
    rows.push_back(mk(1, 1, 1, 0, 3'b110, 0, 8'h00, 1, 0));
    rows.push_back(mk(1, 1, 1, 0, 3'b110, 0, 8'h00, 1, 0));
    rows.push_back(mk(1, 1, 0, 0, 3'b110, 1, B,     1, 0));
    rows.push_back(mk(1, 1, 1, 0, 3'b110, 1, B,     1, 0));
    rows.push_back(mk(1, 1, 1, 0, 3'b110, 1, B,     1, 0));
    rows.push_back(mk(1, 1, 0, 0, 3'b110, 1, B,     2, 1));
    foreach (rows[i]) begin
      resetN = rows[i].rstN; screenActive = rows[i].act; startOfFrame = rows[i].sof;
      newHighScore = rows[i].nhs; layerDR = rows[i].ldr; sb.push_back(rows[i].e);
      @(posedge clk); #1;
      got = '{dr: screenDR, rgb: screenRGB, st: screenState, done: revealDone};
      e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL reveal[%0d] got %h want %h", i, got, e); end
    end
  endtask

  // Without a high score the blink layer stays visible through two full blink half-periods.
  task automatic test_show_steady();
    exp_t e, got;
    for (int i = 0; i < 6; i++) begin
      screenActive = 1; startOfFrame = 1; newHighScore = 0; layerDR = 3'b011;
      sb.push_back('{dr: 1'b1, rgb: A, st: 2'd2, done: 1'b1});
      @(posedge clk); #1;
      got = '{dr: screenDR, rgb: screenRGB, st: screenState, done: revealDone};
      e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL steady[%0d] got %h want %h", i, got, e); end
    end
  endtask

  task automatic test_blink();
    exp_t e, got;
    screenActive = 1; startOfFrame = 0; newHighScore = 1; layerDR = 3'b011;
    sb.push_back('{dr: 1'b1, rgb: A, st: 2'd2, done: 1'b1});
    @(posedge clk); #1;
    got = '{dr: screenDR, rgb: screenRGB, st: screenState, done: revealDone};
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("[TB] FAIL blink_hs got %h want %h", got, e); end
    newHighScore = 0;
    for (int i = 0; i < 12; i++) begin
      startOfFrame = 1;
      sb.push_back('{dr: 1'b1, rgb: (((i / 3) % 2) == 0) ? A : B, st: 2'd2, done: 1'b1});
      @(posedge clk); #1;
      got = '{dr: screenDR, rgb: screenRGB, st: screenState, done: revealDone};
      e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL blink[%0d] got %h want %h", i, got, e); end
    end
  endtask

  task automatic test_exit_midreveal();
    row_t rows[$];
    exp_t e, got;
    rows.push_back(mk(1, 0, 0, 0, 3'b011, 1, A,     0, 0));
    rows.push_back(mk(1, 0, 0, 0, 3'b011, 0, 8'h00, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 3'b111, 0, 8'h00, 1, 0));
    rows.push_back(mk(1, 1, 1, 0, 3'b111, 1, A,     1, 0));
    rows.push_back(mk(1, 1, 1, 0, 3'b111, 1, A,     1, 0));
    rows.push_back(mk(1, 1, 0, 0, 3'b110, 1, B,     1, 0));
    rows.push_back(mk(1, 1, 0, 1, 3'b110, 1, B,     1, 0));
    rows.push_back(mk(1, 0, 0, 0, 3'b110, 1, B,     0, 0));
    rows.push_back(mk(1, 0, 0, 0, 3'b110, 0, 8'h00, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 3'b111, 0, 8'h00, 1, 0));
    rows.push_back(mk(1, 1, 0, 0, 3'b111, 1, A,     1, 0));
    rows.push_back(mk(1, 1, 0, 0, 3'b000, BGON, BGON ? BGC : 8'h00, 1, 0));
    for (int i = 0; i < 4; i++) rows.push_back(mk(1, 1, 1, 0, 3'b011, 1, A, 1, 0));
    rows.push_back(mk(1, 1, 0, 0, 3'b011, 1, A, 2, 1));
    for (int i = 0; i < 6; i++) rows.push_back(mk(1, 1, 1, 0, 3'b011, 1, A, 2, 1));
    foreach (rows[i]) begin
      resetN = rows[i].rstN; screenActive = rows[i].act; startOfFrame = rows[i].sof;
      newHighScore = rows[i].nhs; layerDR = rows[i].ldr; sb.push_back(rows[i].e);
      @(posedge clk); #1;
      got = '{dr: screenDR, rgb: screenRGB, st: screenState, done: revealDone};
      e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL exit[%0d] got %h want %h", i, got, e); end
    end
  endtask

  task automatic test_reset_in_show();
    row_t rows[$];
    exp_t e, got;
    rows.push_back(mk(1, 1, 0, 1, 3'b011, 1, A,     2, 1));
    rows.push_back(mk(1, 1, 1, 0, 3'b011, 1, A,     2, 1));
    rows.push_back(mk(1, 1, 1, 0, 3'b011, 1, A,     2, 1));
    rows.push_back(mk(1, 1, 1, 0, 3'b011, 1, A,     2, 1));
    rows.push_back(mk(1, 1, 1, 0, 3'b011, 1, B,     2, 1));
    rows.push_back(mk(0, 1, 1, 1, 3'b011, 0, 8'h00, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 3'b011, 0, 8'h00, 1, 0));
    rows.push_back(mk(1, 1, 0, 0, 3'b011, 1, A,     1, 0));
    foreach (rows[i]) begin
      resetN = rows[i].rstN; screenActive = rows[i].act; startOfFrame = rows[i].sof;
      newHighScore = rows[i].nhs; layerDR = rows[i].ldr; sb.push_back(rows[i].e);
      @(posedge clk); #1;
      got = '{dr: screenDR, rgb: screenRGB, st: screenState, done: revealDone};
      e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL rst_show[%0d] got %h want %h", i, got, e); end
    end
  endtask

  initial begin
    resetN = 0; screenActive = 0; startOfFrame = 0; newHighScore = 0;
    layerDR = 3'b000; layerRGB = {C, B, A};
    @(posedge clk); #1;
    test_reset();
    test_reveal();
    test_show_steady();
    test_blink();
    test_exit_midreveal();
    test_reset_in_show();
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_left %0d entries, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
